// File: rtl/obi_mem_responder.sv
// OBI responder backed by a word-addressed SRAM with byte-enable writes, grant wait states
// and a fixed-latency response pipeline. Define OBI_MEM_RESPONDER_RANDOM_STALL_EN to add LFSR grant stalls.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int unsigned NUM_WORDS      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned GNT_WAIT       = 0,
    parameter int unsigned RVALID_LATENCY = 1,
    parameter logic [31:0] OOR_RDATA      = 32'hBADC_AC1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  obi_req_t    obi_req_i,
    output obi_resp_t   obi_resp_o,
    output logic [15:0] oor_count_o,
    output logic        busy_o
);

    localparam int unsigned AW        = $clog2(NUM_WORDS);
    localparam logic [31:0] SPAN      = 32'(NUM_WORDS * 4);
    localparam logic [2:0]  WAIT_LOAD = (GNT_WAIT > 1) ? 3'(GNT_WAIT - 1) : 3'd0;
    localparam int unsigned LAST      = RVALID_LATENCY - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GNT
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } pipe_t;

    state_e      state_q;
    logic [2:0]  wcnt_q;
    pipe_t       pipe_q [RVALID_LATENCY];
    pipe_t       pipe_d;
    logic [31:0] mem_q [NUM_WORDS];
    logic [15:0] oor_q;
    logic [15:0] oor_d;

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          stall;
    logic          grant_slot;
    logic          gnt;
    logic [31:0]   resp_data;
    logic          pipe_busy;

    // Decode is relative to BASE_ADDR; the byte offset inside a word is ignored.
    assign off      = obi_req_i.addr - BASE_ADDR;
    assign in_range = (off < SPAN);
    assign word_idx = off[AW+1:2];

`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // With no wait states the grant is combinational from req; otherwise only the GNT state grants.
    assign grant_slot = (GNT_WAIT == 0) ? (state_q != ST_WAIT) : (state_q == ST_GNT);
    assign gnt        = obi_req_i.req && grant_slot && !stall && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (obi_req_i.req && !gnt) begin
                        if (GNT_WAIT <= 1) begin
                            state_q <= ST_GNT;
                        end else begin
                            state_q <= ST_WAIT;
                            wcnt_q  <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!obi_req_i.req) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q - 3'd1;
                        if (wcnt_q == 3'd1) begin
                            state_q <= ST_GNT;
                        end
                    end
                end
                ST_GNT: begin
                    if (gnt || !obi_req_i.req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt && obi_req_i.we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (obi_req_i.be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is taken before this edge's write lands, so a read one cycle after a write sees it.
    always_comb begin
        resp_data = 32'h0;
        if (!obi_req_i.we) begin
            resp_data = in_range ? mem_q[word_idx] : OOR_RDATA;
        end
        pipe_d.valid = gnt;
        pipe_d.rdata = gnt ? resp_data : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_d;
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        oor_d = oor_q;
        if (gnt && !in_range && (oor_q != 16'hFFFF)) begin
            oor_d = oor_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oor_q <= 16'h0;
        end else begin
            oor_q <= oor_d;
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RVALID_LATENCY; i++) begin
            pipe_busy = pipe_busy | pipe_q[i].valid;
        end
    end

    assign busy_o      = (state_q != ST_IDLE) || pipe_busy || (obi_req_i.req && !gnt);
    assign oor_count_o = oor_q;
    assign obi_resp_o  = {gnt, pipe_q[LAST].valid,
                          pipe_q[LAST].valid ? pipe_q[LAST].rdata : 32'h0};

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: four instances with different wait/latency settings, a
// cycle-level model built from due-cycle queues, and directed literal checks.
module tb_obi_mem_responder;
    import obi_pkg::*;

    localparam int NI = 4;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    obi_req_t    req_s  [NI];
    obi_resp_t   resp_s [NI];
    logic        rst_s  [NI];
    logic [15:0] oor_s  [NI];
    logic        busy_s [NI];

    // model state
    int          waited [NI];
    int          due_q  [NI][$];
    logic [31:0] dat_q  [NI][$];
    logic [31:0] mem_m  [NI][1024];
    int          oor_m  [NI];
    bit          armed  [NI];

    // observations of the DUT used by the directed checks
    int          gnt_cyc_q [NI][$];
    int          rv_cyc_q  [NI][$];
    logic [31:0] rd_q      [NI][$];
    int          busy_cnt  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_mem_responder dut0 (
        .clk_i(clk), .rst_i(rst_s[0]), .obi_req_i(req_s[0]), .obi_resp_o(resp_s[0]),
        .oor_count_o(oor_s[0]), .busy_o(busy_s[0])
    );
    obi_mem_responder #(.GNT_WAIT(3), .RVALID_LATENCY(2)) dut1 (
        .clk_i(clk), .rst_i(rst_s[1]), .obi_req_i(req_s[1]), .obi_resp_o(resp_s[1]),
        .oor_count_o(oor_s[1]), .busy_o(busy_s[1])
    );
    obi_mem_responder #(.RVALID_LATENCY(4)) dut2 (
        .clk_i(clk), .rst_i(rst_s[2]), .obi_req_i(req_s[2]), .obi_resp_o(resp_s[2]),
        .oor_count_o(oor_s[2]), .busy_o(busy_s[2])
    );
    obi_mem_responder #(.RVALID_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst_s[3]), .obi_req_i(req_s[3]), .obi_resp_o(resp_s[3]),
        .oor_count_o(oor_s[3]), .busy_o(busy_s[3])
    );

    function automatic int gw(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int rl(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
            end
        end
    endtask

    // Model: a granted transaction responds exactly rl() cycles later, in order.
    always @(negedge clk) begin : model
        logic        egnt, erv, ebusy, inr;
        logic [31:0] edat, a, ent;
        int          idx;
        for (int k = 0; k < NI; k++) begin
            if (armed[k]) begin
                egnt  = req_s[k].req && !rst_s[k] && (waited[k] >= gw(k));
                erv   = (due_q[k].size() > 0) && (due_q[k][0] == cyc);
                edat  = erv ? dat_q[k][0] : 32'h0;
                ebusy = (gw(k) > 0 ? req_s[k].req : (req_s[k].req && !egnt)) || (due_q[k].size() > 0);
                chk("gnt", k, 32'(resp_s[k].gnt), 32'(egnt));
                chk("rvalid", k, 32'(resp_s[k].rvalid), 32'(erv));
                chk("rdata", k, resp_s[k].rdata, edat);
                chk("busy", k, 32'(busy_s[k]), 32'(ebusy));
                chk("oor_count", k, 32'(oor_s[k]), 32'(oor_m[k]));
                if (resp_s[k].gnt) gnt_cyc_q[k].push_back(cyc);
                if (resp_s[k].rvalid) begin
                    rv_cyc_q[k].push_back(cyc);
                    rd_q[k].push_back(resp_s[k].rdata);
                end
                if (busy_s[k]) busy_cnt[k]++;
                if (erv) begin
                    void'(due_q[k].pop_front());
                    void'(dat_q[k].pop_front());
                end
                if (egnt) begin
                    a   = req_s[k].addr;
                    inr = (a < 32'h1000);
                    idx = int'(a[11:2]);
                    ent = 32'h0;
                    if (!inr && oor_m[k] < 65535) oor_m[k]++;
                    if (req_s[k].we) begin
                        if (inr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (req_s[k].be[b]) mem_m[k][idx][8*b +: 8] = req_s[k].wdata[8*b +: 8];
                            end
                        end
                    end else begin
                        ent = inr ? mem_m[k][idx] : 32'hBADC_AC1E;
                    end
                    due_q[k].push_back(cyc + rl(k));
                    dat_q[k].push_back(ent);
                end
                waited[k] = (egnt || !req_s[k].req || rst_s[k]) ? 0 : waited[k] + 1;
            end
            if (rst_s[k]) begin
                due_q[k].delete();
                dat_q[k].delete();
                waited[k] = 0;
                oor_m[k]  = 0;
                armed[k]  = 1'b1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after its accepting edge, leaving req asserted.
    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bit got;
        got = 1'b0;
        req_s[k].req   = 1'b1;
        req_s[k].we    = we;
        req_s[k].be    = be;
        req_s[k].addr  = addr;
        req_s[k].wdata = wdata;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (resp_s[k].gnt) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("gnt_seen", k, 32'(got), 32'd1);
    endtask

    task automatic idle(input int k);
        req_s[k] = '0;
    endtask

    task automatic clr(input int k);
        gnt_cyc_q[k].delete();
        rv_cyc_q[k].delete();
        rd_q[k].delete();
        busy_cnt[k] = 0;
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: run did not complete at cyc %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int c0;
        for (int k = 0; k < NI; k++) begin
            req_s[k] = '0;
            rst_s[k] = 1'b1;
        end
        cycles(3);
        for (int k = 0; k < NI; k++) rst_s[k] = 1'b0;

        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_gnt", k, 32'(resp_s[k].gnt), 32'd0);
            chk("rst_rvalid", k, 32'(resp_s[k].rvalid), 32'd0);
            chk("rst_rdata", k, resp_s[k].rdata, 32'd0);
            chk("rst_oor", k, 32'(oor_s[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_s[k]), 32'd0);
        end
        cycles(1);

        // write then read the same word back-to-back, no wait states
        clr(0);
        c0 = cyc;
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        idle(0);
        cycles(3);
        chk("t1_ngnt", 0, 32'(gnt_cyc_q[0].size()), 32'd2);
        chk("t1_nrv", 0, 32'(rv_cyc_q[0].size()), 32'd2);
        if (rv_cyc_q[0].size() >= 2 && gnt_cyc_q[0].size() >= 2) begin
            chk("t1_gnt_w", 0, 32'(gnt_cyc_q[0][0]), 32'(c0));
            chk("t1_gnt_r", 0, 32'(gnt_cyc_q[0][1]), 32'(c0 + 1));
            chk("t1_rv_r", 0, 32'(rv_cyc_q[0][1]), 32'(c0 + 2));
            chk("t1_wr_rdata", 0, rd_q[0][0], 32'h0);
            chk("t1_rd_rdata", 0, rd_q[0][1], 32'hDEAD_BEEF);
        end

        // byte-enable merge
        clr(0);
        issue(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        issue(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
        idle(0);
        cycles(3);
        chk("t2_nrv", 0, 32'(rd_q[0].size()), 32'd3);
        if (rd_q[0].size() >= 3) chk("t2_merge", 0, rd_q[0][2], 32'h11BB_33DD);

        // out of range accesses
        clr(0);
        issue(0, 1'b1, 32'h0, 32'h55AA_55AA, 4'hF);
        issue(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        issue(0, 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF);
        issue(0, 1'b0, 32'h0, 32'h0, 4'hF);
        idle(0);
        cycles(3);
        chk("t5_nrv", 0, 32'(rd_q[0].size()), 32'd4);
        if (rd_q[0].size() >= 4) begin
            chk("t5_oor_rdata", 0, rd_q[0][1], 32'hBADC_AC1E);
            chk("t5_mem_kept", 0, rd_q[0][3], 32'h55AA_55AA);
        end
        chk("t5_oor_cnt", 0, 32'(oor_s[0]), 32'd2);

        // wait states: GNT_WAIT=3, RVALID_LATENCY=2
        clr(1);
        c0 = cyc;
        issue(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
        idle(1);
        cycles(5);
        chk("t3_ngnt", 1, 32'(gnt_cyc_q[1].size()), 32'd1);
        chk("t3_nrv", 1, 32'(rv_cyc_q[1].size()), 32'd1);
        if (gnt_cyc_q[1].size() >= 1) chk("t3_gnt_cyc", 1, 32'(gnt_cyc_q[1][0] - c0), 32'd3);
        if (rv_cyc_q[1].size() >= 1) chk("t3_rv_cyc", 1, 32'(rv_cyc_q[1][0] - c0), 32'd5);
        chk("t3_busy_cycles", 1, 32'(busy_cnt[1]), 32'd6);
        issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
        idle(1);
        cycles(5);
        if (rd_q[1].size() >= 2) chk("t3_readback", 1, rd_q[1][1], 32'h1234_5678);
        else chk("t3_nrv2", 1, 32'(rd_q[1].size()), 32'd2);

        // pipelining: RVALID_LATENCY=4, four reads on consecutive cycles
        clr(2);
        for (int i = 0; i < 4; i++) issue(2, 1'b1, 32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF);
        c0 = cyc;
        for (int i = 0; i < 4; i++) issue(2, 1'b0, 32'(4 * i), 32'h0, 4'hF);
        idle(2);
        cycles(6);
        chk("t4_nrv", 2, 32'(rv_cyc_q[2].size()), 32'd8);
        if (rv_cyc_q[2].size() >= 8) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4_rv_cyc", 2, 32'(rv_cyc_q[2][4 + i] - c0), 32'(4 + i));
                chk("t4_rdata", 2, rd_q[2][4 + i], 32'hC0DE_0000 | 32'(i));
            end
        end

        // reset with a read in flight: RVALID_LATENCY=3
        issue(3, 1'b1, 32'h80, 32'h600D_F00D, 4'hF);
        idle(3);
        cycles(4);
        issue(3, 1'b0, 32'h4000, 32'h0, 4'hF);
        idle(3);
        cycles(4);
        chk("t6_oor_pre", 3, 32'(oor_s[3]), 32'd1);
        clr(3);
        issue(3, 1'b0, 32'h80, 32'h0, 4'hF);
        idle(3);
        rst_s[3] = 1'b1;
        cycles(1);
        rst_s[3] = 1'b0;
        cycles(6);
        chk("t6_ngnt", 3, 32'(gnt_cyc_q[3].size()), 32'd1);
        chk("t6_no_rvalid", 3, 32'(rv_cyc_q[3].size()), 32'd0);
        chk("t6_oor_post", 3, 32'(oor_s[3]), 32'd0);
        clr(3);
        c0 = cyc;
        issue(3, 1'b0, 32'h80, 32'h0, 4'hF);
        idle(3);
        cycles(4);
        chk("t6_nrv", 3, 32'(rv_cyc_q[3].size()), 32'd1);
        if (rv_cyc_q[3].size() >= 1) begin
            chk("t6_rv_cyc", 3, 32'(rv_cyc_q[3][0] - c0), 32'd3);
            chk("t6_rdata", 3, rd_q[3][0], 32'h600D_F00D);
        end

        // out-of-range counter saturation with a continuously held read
        clr(0);
        req_s[0].req   = 1'b1;
        req_s[0].we    = 1'b0;
        req_s[0].be    = 4'hF;
        req_s[0].addr  = 32'h1000;
        req_s[0].wdata = 32'h0;
        cycles(65540);
        idle(0);
        cycles(3);
        chk("t7_oor_sat", 0, 32'(oor_s[0]), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
